lcd_frame_writer: RTL and testbench
===================================

Name: lcd_frame_writer

Overview:
- Consumes the 32-character display string (strdata) and the change strobe (cls) produced by the CPU top level.
- Drives the HD44780-compatible character LCD in 4-bit mode.
- Performs the power-on init sequence, then writes both 16-char lines whenever a refresh is requested.
- Sits directly downstream of the top-level string builder and directly upstream of the LCD pins.

Parameters:
- T_PWRON, 750000, cycles of power-on wait before first init nibble (15 ms at 50 MHz).
- T_INIT1, 205000, wait after first init nibble (4.1 ms).
- T_INIT2, 5000, wait after second init nibble (100 us).
- T_CMD, 2000, wait after every byte except clear (40 us).
- T_CLR, 82000, wait after clear-display byte (1.64 ms).
- T_NIB, 50, gap between high and low nibble of a byte (1 us).
- T_EHI, 12, E-high pulse width in cycles.

Ports:
- CCLK  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- strdata  in  256  32 ASCII chars; [255:248] = line 1 col 0; [127:120] = line 2 col 0; [7:0] = line 2 col 15.
- cls  in  1  refresh request, level or pulse; sampled every cycle.
- lcd_rs  out  1  register select (0 = command, 1 = data).
- lcd_rw  out  1  always 0 (write only).
- lcd_e  out  1  enable strobe.
- lcd_dat  out  4  data nibble (DB7..DB4).
- ready  out  1  1 when idle and able to start a frame immediately.

Behaviour:
- Reset (rst low, async): lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_dat=0, ready=0, pending=1, shadow=0; FSM to PWR_WAIT. Reset mid-frame abandons the frame; the full power-on sequence reruns.
- Nibble transfer:
  - lcd_rs and lcd_dat are valid 2 cycles before E rises.
  - E is high for T_EHI cycles.
  - lcd_rs and lcd_dat are held 2 cycles after E falls.
  - Total per nibble = T_EHI+4 cycles.
- Byte transfer: high nibble, T_NIB wait, low nibble, then post-wait (T_CLR if byte=0x01 with rs=0, else T_CMD).
- FSM states and transitions:
  - PWR_WAIT: count T_PWRON, then go to INIT.
  - INIT: single nibbles 0x3 (wait T_INIT1), 0x3 (T_INIT2), 0x3 (T_CMD), 0x2 (T_CMD), then go to CFG.
  - CFG: bytes 0x28, 0x06, 0x0C, 0x01, then go to IDLE.
  - IDLE: ready=1. If pending|cls: capture strdata into the 256-bit shadow, clear pending, go to ADDR1.
  - ADDR1: cmd 0x80, then go to LINE1.
  - LINE1: 16 data bytes from shadow[255:128], MSB char first, then go to ADDR2.
  - ADDR2: cmd 0xC0, then go to LINE2.
  - LINE2: 16 data bytes from shadow[127:0], then go to IDLE.
- The first frame after init is always written (pending=1 from reset) with whatever strdata holds.
- cls outside IDLE sets pending; the shadow is untouched mid-frame, so the frame in flight shows a consistent snapshot. After that frame completes, one extra frame is written with fresh data. Multiple cls pulses during one frame collapse to one extra frame.
- cls in IDLE on the same cycle as entry from LINE2: treated as an IDLE request (captured next cycle), not lost.
- Character index is a 5-bit counter 0..15 per line; it wraps to 0 when the line ends.
- Wait counter is 20 bits; it must hold T_PWRON. Saturation is not needed.
- ready drops on the cycle after capture and rises on entry to IDLE.

Decomposition:
- Shared package: LCD command constants (FUNC_SET=0x28, ENTRY=0x06, DISP_ON=0x0C, CLEAR=0x01, LINE1=0x80, LINE2=0xC0) and the FSM state enum.
- One sub-module, lcd_nibble_tx:
  - Accepts start, rs, byte, single_nibble flag and post_wait count.
  - Performs the setup/E-pulse/hold/gap timing.
  - Returns done.
- The top FSM only sequences bytes.

Test Plan (all T_* parameters scaled to 1..20 for simulation):
- Reset then release -> no E pulse for T_PWRON cycles; then nibbles 3,3,3,2 on lcd_dat with lcd_rs=0; then bytes 28,06,0C,01; 01 is followed by a T_CLR gap before the next E.
- strdata="01234567 00 0123f01d01e01m01w01 " after init -> 0x80 then data 0x30..0x37,0x20,... rs=1; 0xC0; line 2 ends with 0x31,0x20; ready=1 afterward.
- In IDLE, change strdata[255:248] to 0x41, pulse cls 1 cycle -> ready=0 next cycle; the first data byte after 0x80 is 0x41; exactly one frame is written.
- Three cls pulses during LINE1, strdata changed between them -> the current frame keeps its captured data; exactly one extra frame follows, using strdata at its IDLE capture.
- Assert rst during LINE2 -> outputs 0 immediately (async), ready=0; after release the full init sequence repeats before any data byte.
- Throughout all tests: lcd_rw==0; lcd_dat/lcd_rs stable from 2 cycles before E rises to 2 cycles after E falls; E high exactly T_EHI cycles.

Source files
------------

// File: rtl/lcd_frame_writer_pkg.sv
// ---------------------------------------------------------------------------
// lcd_frame_writer_pkg
// Shared definitions for the character-LCD frame writer:
//   - display string width and wait-counter type
//   - HD44780 command bytes used by the init/config/refresh sequences
//   - frame sequencer state codes
//   - helpers: configuration command lookup and character extraction
// ---------------------------------------------------------------------------
package lcd_frame_writer_pkg;

   localparam int STR_W  = 256;   // 32 chars x 8 bits
   localparam int WAIT_W = 20;    // wide enough for the power-on wait

   typedef logic [WAIT_W-1:0] wait_t;

   // HD44780 commands
   localparam logic [7:0] CMD_FUNC_SET = 8'h28;   // 4-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] CMD_ENTRY    = 8'h06;   // increment, no shift
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;   // display on, cursor off
   localparam logic [7:0] CMD_CLEAR    = 8'h01;   // clear display (slow command)
   localparam logic [7:0] CMD_LINE1    = 8'h80;   // DDRAM address 0x00
   localparam logic [7:0] CMD_LINE2    = 8'hC0;   // DDRAM address 0x40

   // Init nibbles are sent as the high nibble of these bytes
   localparam logic [7:0] INIT_WAKE    = 8'h30;
   localparam logic [7:0] INIT_4BIT    = 8'h20;

   // Frame sequencer states
   typedef logic [2:0] fsm_state_t;
   localparam fsm_state_t ST_PWR_WAIT = 3'd0;
   localparam fsm_state_t ST_INIT     = 3'd1;
   localparam fsm_state_t ST_CFG      = 3'd2;
   localparam fsm_state_t ST_IDLE     = 3'd3;
   localparam fsm_state_t ST_ADDR1    = 3'd4;
   localparam fsm_state_t ST_LINE1    = 3'd5;
   localparam fsm_state_t ST_ADDR2    = 3'd6;
   localparam fsm_state_t ST_LINE2    = 3'd7;

   // Configuration byte for step 0..3 of the CFG phase
   function automatic logic [7:0] cfg_cmd(input logic [1:0] step);
      logic [7:0] cmd;
      case (step)
         2'd0:    cmd = CMD_FUNC_SET;
         2'd1:    cmd = CMD_ENTRY;
         2'd2:    cmd = CMD_DISP_ON;
         default: cmd = CMD_CLEAR;
      endcase
      return cmd;
   endfunction

   // Character at (line, col); line 1 col 0 lives in the top byte.
   // Linear position p = {line2, col}; its byte sits at bit 8*(31-p),
   // and 31-p is simply ~p for a 5-bit p.
   function automatic logic [7:0] char_at(input logic [STR_W-1:0] s,
                                          input logic             line2,
                                          input logic [3:0]       col);
      logic [4:0] pos;
      pos = {line2, col};
      return s[{~pos, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// ---------------------------------------------------------------------------
// lcd_frame_writer_if
// Bundles the string/refresh inputs, the ready status and the LCD pins.
//   strdata  : 32-char display string (line 1 col 0 in [255:248])
//   cls      : refresh request
//   ready    : writer idle and able to start a frame immediately
//   lcd_rs/lcd_rw/lcd_e/lcd_dat : HD44780 4-bit bus
// Modports: master = string builder / pin observer, slave = the writer.
// ---------------------------------------------------------------------------
interface lcd_frame_writer_if;
   import lcd_frame_writer_pkg::*;

   logic [STR_W-1:0] strdata;
   logic             cls;
   logic             ready;
   logic             lcd_rs;
   logic             lcd_rw;
   logic             lcd_e;
   logic [3:0]       lcd_dat;

   modport master (output strdata, cls,
                   input  ready, lcd_rs, lcd_rw, lcd_e, lcd_dat);

   modport slave  (input  strdata, cls,
                   output ready, lcd_rs, lcd_rw, lcd_e, lcd_dat);

endinterface

// File: rtl/lcd_nibble_tx.sv
// ---------------------------------------------------------------------------
// lcd_nibble_tx
// Sends one byte (two nibbles) or a single nibble to the LCD with bus timing:
//   data/rs valid 2 cycles before E rises, E high T_EHI cycles, data/rs held
//   2 cycles after E falls, T_NIB cycles between the two nibbles of a byte,
//   then post_wait cycles before done.
// Ports:
//   CCLK, rst      clock, asynchronous active-low reset
//   start          accept a transfer (only honoured while idle)
//   rs             register select for the transfer
//   data_byte      byte to send; single-nibble mode sends data_byte[7:4]
//   single_nibble  send only the high nibble
//   post_wait      cycles to wait after the last nibble
//   done           one-cycle pulse when the transfer and post-wait finish
//   lcd_rs, lcd_e, lcd_dat   LCD pins
// ---------------------------------------------------------------------------
module lcd_nibble_tx
   import lcd_frame_writer_pkg::*;
#(
   parameter int T_NIB = 50,
   parameter int T_EHI = 12
) (
   input  logic       CCLK,
   input  logic       rst,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] data_byte,
   input  logic       single_nibble,
   input  wait_t      post_wait,
   output logic       done,
   output logic       lcd_rs,
   output logic       lcd_e,
   output logic [3:0] lcd_dat
);

   localparam logic [2:0] PH_IDLE  = 3'd0;
   localparam logic [2:0] PH_SETUP = 3'd1;
   localparam logic [2:0] PH_EHI   = 3'd2;
   localparam logic [2:0] PH_HOLD  = 3'd3;
   localparam logic [2:0] PH_GAP   = 3'd4;
   localparam logic [2:0] PH_POST  = 3'd5;

   localparam wait_t EHI_LAST = wait_t'(T_EHI - 1);
   localparam wait_t NIB_LAST = wait_t'(T_NIB - 1);
   localparam wait_t TWO_LAST = wait_t'(1);

   logic [2:0] phase_reg;
   wait_t      cnt_reg;
   wait_t      post_reg;
   logic [3:0] lo_reg;
   logic       second_reg;   // low nibble still to send

   always_ff @(posedge CCLK or negedge rst) begin
      if (!rst) begin
         phase_reg  <= PH_IDLE;
         cnt_reg    <= '0;
         post_reg   <= '0;
         lo_reg     <= 4'h0;
         second_reg <= 1'b0;
         done       <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_e      <= 1'b0;
         lcd_dat    <= 4'h0;
      end else begin
         done <= 1'b0;
         case (phase_reg)
            PH_IDLE: begin
               if (start) begin
                  lcd_rs     <= rs;
                  lcd_dat    <= data_byte[7:4];
                  lo_reg     <= data_byte[3:0];
                  second_reg <= !single_nibble;
                  post_reg   <= post_wait;
                  cnt_reg    <= TWO_LAST;
                  phase_reg  <= PH_SETUP;
               end
            end
            PH_SETUP: begin
               if (cnt_reg == '0) begin
                  lcd_e     <= 1'b1;
                  cnt_reg   <= EHI_LAST;
                  phase_reg <= PH_EHI;
               end else begin
                  cnt_reg <= cnt_reg - wait_t'(1);
               end
            end
            PH_EHI: begin
               if (cnt_reg == '0) begin
                  lcd_e     <= 1'b0;
                  cnt_reg   <= TWO_LAST;
                  phase_reg <= PH_HOLD;
               end else begin
                  cnt_reg <= cnt_reg - wait_t'(1);
               end
            end
            PH_HOLD: begin
               if (cnt_reg == '0) begin
                  if (second_reg) begin
                     second_reg <= 1'b0;
                     cnt_reg    <= NIB_LAST;
                     phase_reg  <= PH_GAP;
                  end else if (post_reg == '0) begin
                     done      <= 1'b1;
                     phase_reg <= PH_IDLE;
                  end else begin
                     cnt_reg   <= post_reg - wait_t'(1);
                     phase_reg <= PH_POST;
                  end
               end else begin
                  cnt_reg <= cnt_reg - wait_t'(1);
               end
            end
            PH_GAP: begin
               // Low nibble goes out at the end of the gap, then gets its
               // own 2-cycle setup before E.
               if (cnt_reg == '0) begin
                  lcd_dat   <= lo_reg;
                  cnt_reg   <= TWO_LAST;
                  phase_reg <= PH_SETUP;
               end else begin
                  cnt_reg <= cnt_reg - wait_t'(1);
               end
            end
            PH_POST: begin
               if (cnt_reg == '0) begin
                  done      <= 1'b1;
                  phase_reg <= PH_IDLE;
               end else begin
                  cnt_reg <= cnt_reg - wait_t'(1);
               end
            end
            default: phase_reg <= PH_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/lcd_frame_writer.sv
// ---------------------------------------------------------------------------
// lcd_frame_writer
// Drives an HD44780 character LCD in 4-bit mode: power-on wait, init
// nibbles, configuration bytes, then a full two-line refresh whenever one
// is requested. Byte timing is delegated to lcd_nibble_tx; this module only
// sequences what is sent.
// Ports:
//   CCLK   system clock
//   rst    asynchronous reset, active-low
//   bus    slave side of lcd_frame_writer_if (strdata, cls, ready, LCD pins)
// ---------------------------------------------------------------------------
module lcd_frame_writer
   import lcd_frame_writer_pkg::*;
#(
   parameter int T_PWRON = 750000,
   parameter int T_INIT1 = 205000,
   parameter int T_INIT2 = 5000,
   parameter int T_CMD   = 2000,
   parameter int T_CLR   = 82000,
   parameter int T_NIB   = 50,
   parameter int T_EHI   = 12
) (
   input  logic              CCLK,
   input  logic              rst,
   lcd_frame_writer_if.slave bus
);

   localparam wait_t PWRON_LAST = wait_t'(T_PWRON - 1);

   fsm_state_t       state_reg;
   logic [4:0]       idx_reg;       // init step, config step or character column
   wait_t            wait_reg;
   logic             issued_reg;    // current step handed to the transmitter
   logic             pending_reg;   // refresh requested but not yet captured
   logic             ready_reg;
   logic [STR_W-1:0] shadow_reg;    // snapshot being displayed

   logic             sending;
   logic             tx_start;
   logic             tx_rs;
   logic             tx_single;
   logic [7:0]       tx_byte;
   wait_t            tx_post;
   logic             tx_done;

   // What the current step sends
   always_comb begin
      sending   = (state_reg != ST_PWR_WAIT) && (state_reg != ST_IDLE);
      tx_start  = sending && !issued_reg;
      tx_rs     = 1'b0;
      tx_single = 1'b0;
      tx_byte   = 8'h00;
      tx_post   = wait_t'(T_CMD);
      case (state_reg)
         ST_INIT: begin
            tx_single = 1'b1;
            tx_byte   = (idx_reg == 5'd3) ? INIT_4BIT : INIT_WAKE;
            if (idx_reg == 5'd0)
               tx_post = wait_t'(T_INIT1);
            else if (idx_reg == 5'd1)
               tx_post = wait_t'(T_INIT2);
         end
         ST_CFG:   tx_byte = cfg_cmd(idx_reg[1:0]);
         ST_ADDR1: tx_byte = CMD_LINE1;
         ST_LINE1: begin
            tx_rs   = 1'b1;
            tx_byte = char_at(shadow_reg, 1'b0, idx_reg[3:0]);
         end
         ST_ADDR2: tx_byte = CMD_LINE2;
         ST_LINE2: begin
            tx_rs   = 1'b1;
            tx_byte = char_at(shadow_reg, 1'b1, idx_reg[3:0]);
         end
         default: ;
      endcase
      // Clear display is the one slow command
      if (!tx_rs && !tx_single && tx_byte == CMD_CLEAR)
         tx_post = wait_t'(T_CLR);
   end

   always_ff @(posedge CCLK or negedge rst) begin
      if (!rst) begin
         state_reg   <= ST_PWR_WAIT;
         idx_reg     <= 5'd0;
         wait_reg    <= '0;
         issued_reg  <= 1'b0;
         pending_reg <= 1'b1;
         ready_reg   <= 1'b0;
         shadow_reg  <= '0;
      end else begin
         // Any request seen outside a capture is remembered; the IDLE
         // capture below overrides this when it consumes the request.
         if (bus.cls)
            pending_reg <= 1'b1;

         if (tx_start)
            issued_reg <= 1'b1;
         else if (tx_done)
            issued_reg <= 1'b0;

         case (state_reg)
            ST_PWR_WAIT: begin
               if (wait_reg == PWRON_LAST) begin
                  wait_reg  <= '0;
                  idx_reg   <= 5'd0;
                  state_reg <= ST_INIT;
               end else begin
                  wait_reg <= wait_reg + wait_t'(1);
               end
            end
            ST_INIT: begin
               if (tx_done) begin
                  if (idx_reg == 5'd3) begin
                     idx_reg   <= 5'd0;
                     state_reg <= ST_CFG;
                  end else begin
                     idx_reg <= idx_reg + 5'd1;
                  end
               end
            end
            ST_CFG: begin
               if (tx_done) begin
                  if (idx_reg == 5'd3) begin
                     idx_reg   <= 5'd0;
                     ready_reg <= 1'b1;
                     state_reg <= ST_IDLE;
                  end else begin
                     idx_reg <= idx_reg + 5'd1;
                  end
               end
            end
            ST_IDLE: begin
               if (pending_reg || bus.cls) begin
                  shadow_reg  <= bus.strdata;
                  pending_reg <= 1'b0;
                  ready_reg   <= 1'b0;
                  state_reg   <= ST_ADDR1;
               end
            end
            ST_ADDR1: begin
               if (tx_done)
                  state_reg <= ST_LINE1;
            end
            ST_LINE1: begin
               if (tx_done) begin
                  if (idx_reg == 5'd15) begin
                     idx_reg   <= 5'd0;
                     state_reg <= ST_ADDR2;
                  end else begin
                     idx_reg <= idx_reg + 5'd1;
                  end
               end
            end
            ST_ADDR2: begin
               if (tx_done)
                  state_reg <= ST_LINE2;
            end
            ST_LINE2: begin
               if (tx_done) begin
                  if (idx_reg == 5'd15) begin
                     idx_reg   <= 5'd0;
                     ready_reg <= 1'b1;
                     state_reg <= ST_IDLE;
                  end else begin
                     idx_reg <= idx_reg + 5'd1;
                  end
               end
            end
            default: state_reg <= ST_PWR_WAIT;
         endcase
      end
   end

   lcd_nibble_tx #(
      .T_NIB (T_NIB),
      .T_EHI (T_EHI)
   ) u_tx (
      .CCLK          (CCLK),
      .rst           (rst),
      .start         (tx_start),
      .rs            (tx_rs),
      .data_byte     (tx_byte),
      .single_nibble (tx_single),
      .post_wait     (tx_post),
      .done          (tx_done),
      .lcd_rs        (bus.lcd_rs),
      .lcd_e         (bus.lcd_e),
      .lcd_dat       (bus.lcd_dat)
   );

   assign bus.lcd_rw = 1'b0;
   assign bus.ready  = ready_reg;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_frame_writer
// Directed sequence with random display text. A pin monitor decodes every
// E pulse into (rs, nibble) and checks bus timing; the expected nibble
// stream is built from the display text and the command sequence.
// ---------------------------------------------------------------------------
module tb_lcd_frame_writer;

   localparam int P_PWRON = 20;
   localparam int P_INIT1 = 15;
   localparam int P_INIT2 = 8;
   localparam int P_CMD   = 5;
   localparam int P_CLR   = 18;
   localparam int P_NIB   = 3;
   localparam int P_EHI   = 4;

   localparam int INIT_NIBS  = 12;   // 4 single nibbles + 4 config bytes
   localparam int FRAME_NIBS = 68;   // 2 address bytes + 32 characters

   typedef logic [7:0] text_t [32];

   logic CCLK = 1'b0;
   logic rst  = 1'b0;

   lcd_frame_writer_if bus();

   lcd_frame_writer #(
      .T_PWRON (P_PWRON),
      .T_INIT1 (P_INIT1),
      .T_INIT2 (P_INIT2),
      .T_CMD   (P_CMD),
      .T_CLR   (P_CLR),
      .T_NIB   (P_NIB),
      .T_EHI   (P_EHI)
   ) dut (
      .CCLK (CCLK),
      .rst  (rst),
      .bus  (bus.slave)
   );

   always #5 CCLK = ~CCLK;

   int n_total = 0;
   int n_pass  = 0;

   // ---------------- pin monitor ----------------
   int         cyc = 0;
   int         viol = 0;
   logic [4:0] nib_q [$];
   int         rise_q [$];
   int         fall_q [$];
   logic       prev_e = 1'b0;
   logic       prev_rs = 1'b0;
   logic [3:0] prev_dat = 4'h0;
   int         stable = 0;
   int         ehi = 0;
   int         hold_left = 0;

   always @(negedge CCLK) begin
      logic changed;
      cyc = cyc + 1;
      if (!rst) begin
         prev_e = 1'b0; prev_rs = 1'b0; prev_dat = 4'h0;
         stable = 0; ehi = 0; hold_left = 0;
      end else begin
         changed = ({bus.lcd_rs, bus.lcd_dat} != {prev_rs, prev_dat});
         if (bus.lcd_rw !== 1'b0) viol = viol + 1;
         if (changed) begin
            if (bus.lcd_e || prev_e || hold_left > 0) viol = viol + 1;
            stable = 1;
         end else begin
            stable = stable + 1;
         end
         if (hold_left > 0) hold_left = hold_left - 1;
         if (bus.lcd_e && !prev_e) begin
            if (stable < 3) viol = viol + 1;
            nib_q.push_back({bus.lcd_rs, bus.lcd_dat});
            rise_q.push_back(cyc);
            ehi = 1;
         end else if (bus.lcd_e) begin
            ehi = ehi + 1;
         end else if (prev_e) begin
            if (ehi != P_EHI) viol = viol + 1;
            fall_q.push_back(cyc);
            hold_left = 1;
         end
         prev_e = bus.lcd_e; prev_rs = bus.lcd_rs; prev_dat = bus.lcd_dat;
      end
   end

   // ---------------- expected model ----------------
   logic [4:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic exp_byte(input logic rs, input logic [7:0] b);
      exp_q.push_back({rs, b[7:4]});
      exp_q.push_back({rs, b[3:0]});
   endtask

   task automatic exp_init();
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h02);
      exp_byte(1'b0, 8'h28);
      exp_byte(1'b0, 8'h06);
      exp_byte(1'b0, 8'h0C);
      exp_byte(1'b0, 8'h01);
   endtask

   task automatic exp_frame(input text_t t);
      exp_byte(1'b0, 8'h80);
      for (int c = 0; c < 16; c++) exp_byte(1'b1, t[c]);
      exp_byte(1'b0, 8'hC0);
      for (int c = 16; c < 32; c++) exp_byte(1'b1, t[c]);
   endtask

   function automatic logic [255:0] pack(input text_t t);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) r[255 - 8*i -: 8] = t[i];
      return r;
   endfunction

   task automatic rand_text(output text_t t);
      for (int i = 0; i < 32; i++) t[i] = 8'($urandom_range(32, 126));
   endtask

   task automatic clear_all();
      nib_q.delete(); rise_q.delete(); fall_q.delete(); exp_q.delete();
   endtask

   task automatic compare_stream(input string tag);
      int n;
      check({tag, " count"}, nib_q.size(), exp_q.size());
      n = (nib_q.size() < exp_q.size()) ? nib_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s nib%0d", tag, i), 32'(nib_q[i]), 32'(exp_q[i]));
      check({tag, " timing"}, viol, 0);
   endtask

   task automatic wait_nibs(input string tag, input int n, input int budget);
      int k = 0;
      while (nib_q.size() < n && k < budget) begin
         @(negedge CCLK);
         k++;
      end
      check({tag, " nibbles arrived"}, 32'(nib_q.size() >= n), 32'd1);
   endtask

   task automatic wait_ready(input string tag, input int budget);
      int k = 0;
      while (bus.ready !== 1'b1 && k < budget) begin
         @(negedge CCLK);
         k++;
      end
      check({tag, " ready"}, 32'(bus.ready), 32'd1);
   endtask

   task automatic pulse_cls();
      @(negedge CCLK);
      bus.cls = 1'b1;
      @(negedge CCLK);
      bus.cls = 1'b0;
   endtask

   task automatic check_init_gaps(input string tag, input int rel_cyc);
      if (rise_q.size() >= 13 && fall_q.size() >= 12) begin
         check({tag, " pwron gap"}, 32'(rise_q[0] - rel_cyc >= P_PWRON), 32'd1);
         check({tag, " init1 gap"}, 32'(rise_q[1] - fall_q[0] >= P_INIT1), 32'd1);
         check({tag, " init2 gap"}, 32'(rise_q[2] - fall_q[1] >= P_INIT2), 32'd1);
         check({tag, " nibble gap"}, 32'(rise_q[5] - fall_q[4] >= P_NIB), 32'd1);
         check({tag, " clear gap"}, 32'(rise_q[12] - fall_q[11] >= P_CLR), 32'd1);
      end else begin
         check({tag, " gap data present"}, 32'(rise_q.size()), 32'd13);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      text_t cur;
      string s;
      int    rel_cyc;

      bus.cls = 1'b0;
      s = "01234567 00 0123f01d01e01m01w01 ";
      for (int i = 0; i < 32; i++) cur[i] = s[i];
      bus.strdata = pack(cur);

      // Reset state
      rst = 1'b0;
      repeat (3) @(negedge CCLK);
      check("reset lcd_e", 32'(bus.lcd_e), 32'd0);
      check("reset lcd_rs", 32'(bus.lcd_rs), 32'd0);
      check("reset lcd_rw", 32'(bus.lcd_rw), 32'd0);
      check("reset lcd_dat", 32'(bus.lcd_dat), 32'd0);
      check("reset ready", 32'(bus.ready), 32'd0);

      // Power-on init and the automatic first frame
      rst = 1'b1;
      rel_cyc = cyc;
      exp_init();
      exp_frame(cur);
      wait_nibs("boot", INIT_NIBS + FRAME_NIBS, 8000);
      wait_ready("boot", 500);
      compare_stream("boot");
      check_init_gaps("boot", rel_cyc);
      $display("boot: init + frame, %0d nibbles", nib_q.size());
      clear_all();

      // Single refresh from IDLE
      rand_text(cur);
      cur[0] = 8'h41;
      bus.strdata = pack(cur);
      check("idle ready before cls", 32'(bus.ready), 32'd1);
      pulse_cls();
      check("ready drops after cls", 32'(bus.ready), 32'd0);
      exp_frame(cur);
      wait_nibs("refresh", FRAME_NIBS, 4000);
      wait_ready("refresh", 500);
      repeat (150) @(negedge CCLK);
      compare_stream("refresh");
      $display("refresh: one frame, %0d nibbles", nib_q.size());
      clear_all();

      // Three requests during LINE1 collapse into one extra frame
      rand_text(cur);
      bus.strdata = pack(cur);
      pulse_cls();
      exp_frame(cur);
      wait_nibs("line1 entry", 8, 1000);
      for (int p = 0; p < 3; p++) begin
         rand_text(cur);
         bus.strdata = pack(cur);
         pulse_cls();
         repeat (15) @(negedge CCLK);
      end
      exp_frame(cur);
      wait_nibs("collapse", 2 * FRAME_NIBS, 8000);
      wait_ready("collapse", 500);
      repeat (300) @(negedge CCLK);
      compare_stream("collapse");
      $display("collapse: two frames, %0d nibbles", nib_q.size());
      clear_all();

      // Asynchronous reset during LINE2
      rand_text(cur);
      bus.strdata = pack(cur);
      pulse_cls();
      wait_nibs("line2 entry", 40, 3000);
      @(negedge CCLK);
      #2 rst = 1'b0;
      #1;
      check("async lcd_e", 32'(bus.lcd_e), 32'd0);
      check("async lcd_rs", 32'(bus.lcd_rs), 32'd0);
      check("async lcd_dat", 32'(bus.lcd_dat), 32'd0);
      check("async lcd_rw", 32'(bus.lcd_rw), 32'd0);
      check("async ready", 32'(bus.ready), 32'd0);
      clear_all();
      rand_text(cur);
      bus.strdata = pack(cur);
      repeat (3) @(negedge CCLK);
      rst = 1'b1;
      rel_cyc = cyc;
      exp_init();
      exp_frame(cur);
      wait_nibs("reboot", INIT_NIBS + FRAME_NIBS, 8000);
      wait_ready("reboot", 500);
      compare_stream("reboot");
      check_init_gaps("reboot", rel_cyc);
      $display("reboot: init + frame, %0d nibbles", nib_q.size());
      clear_all();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
